// File: rtl/prefix_pkg.sv
// prefix_pkg: shared types and constants for the x86 prefix tracker.
//   prefix_kind_t  - prefix byte class reported by the decoder
//   prefix_state_t - instruction-phase state of the tracker
//   ES..GS         - segment register indices
//   sr_in_range    - true when a segment index names a register that exists
package prefix_pkg;

    typedef enum logic [1:0] {
        SEG   = 2'd0,
        REP   = 2'd1,
        REPNE = 2'd2,
        LOCK  = 2'd3
    } prefix_kind_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EXEC    = 2'd2
    } prefix_state_t;

    localparam int ES = 0;
    localparam int CS = 1;
    localparam int SS = 2;
    localparam int DS = 3;
    localparam int FS = 4;
    localparam int GS = 5;

    // Compared as int so the check stays meaningful when the index field
    // is exactly wide enough for the register count.
    function automatic logic sr_in_range(input int idx, input int num_sr);
        return (idx < num_sr) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with a sticky overflow flag.
//   clk      in  clock
//   reset    in  synchronous active-high reset
//   clear    in  zero count and overflow; applied before inc in the same cycle
//   inc      in  increment request
//   count    out current count, saturates at MAX
//   overflow out set when an increment is requested while already at MAX
module sat_counter #(
    parameter int MAX = 15,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         overflow
);

    logic [W-1:0] base_count_s;
    logic         base_ovf_s;
    logic [W-1:0] count_next_s;
    logic         ovf_next_s;

    // Next count/overflow: clear first, then apply the increment.
    always_comb begin
        base_count_s = count;
        base_ovf_s   = overflow;
        if (clear) begin
            base_count_s = {W{1'b0}};
            base_ovf_s   = 1'b0;
        end else begin
            base_count_s = count;
            base_ovf_s   = overflow;
        end
        count_next_s = base_count_s;
        ovf_next_s   = base_ovf_s;
        if (inc && (base_count_s == W'(MAX))) begin
            ovf_next_s = 1'b1;
        end else if (inc) begin
            count_next_s = base_count_s + W'(1);
        end else begin
            count_next_s = base_count_s;
        end
    end

    // Count and overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= {W{1'b0}};
            overflow <= 1'b0;
        end else begin
            count    <= count_next_s;
            overflow <= ovf_next_s;
        end
    end

endmodule

// File: rtl/prefix_tracker.sv
// prefix_tracker: collects x86 prefixes between instruction boundaries and
// selects the segment register for memory operands.
//   clk, reset           clock, synchronous active-high reset
//   next_instruction     boundary strobe, clears all prefix state
//   prefix_valid/kind/sr decoder prefix byte strobe, class and segment index
//   opcode_start         opcode consumed, prefix collection ends
//   force_segment        microcode select overrides everything
//   bp_is_base           address uses BP, default segment becomes BP_SR
//   microcode_sr_rd_sel  microcode default segment
//   sr_rd_sel            segment register read select (combinational)
//   override_active, rep_active, rep_ne, lock_active   prefix flags
//   prefix_count, prefix_overflow                      saturating prefix count
module prefix_tracker
    import prefix_pkg::*;
#(
    parameter int NUM_SR       = 4,
    parameter int MAX_PREFIXES = 15,
    parameter int BP_SR        = 2,
    localparam int SR_W        = $clog2(NUM_SR),
    localparam int CNT_W       = $clog2(MAX_PREFIXES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             next_instruction,
    input  logic             prefix_valid,
    input  prefix_kind_t     prefix_kind,
    input  logic [SR_W-1:0]  prefix_sr,
    input  logic             opcode_start,
    input  logic             force_segment,
    input  logic             bp_is_base,
    input  logic [SR_W-1:0]  microcode_sr_rd_sel,
    output logic [SR_W-1:0]  sr_rd_sel,
    output logic             override_active,
    output logic             rep_active,
    output logic             rep_ne,
    output logic             lock_active,
    output logic [CNT_W-1:0] prefix_count,
    output logic             prefix_overflow
);

    prefix_state_t   state_r;
    prefix_state_t   state_next_s;
    prefix_state_t   base_state_s;
    logic            accept_s;
    logic            seg_now_s;
    logic [SR_W-1:0] seg_sr_s;
    logic [SR_W-1:0] override_r;

    // A boundary in the same cycle re-opens collection, so a prefix arriving
    // with next_instruction is accepted even from EXEC.
    assign accept_s  = prefix_valid && (next_instruction || (state_r != EXEC));
    assign seg_now_s = prefix_valid && (prefix_kind == SEG);
    assign seg_sr_s  = sr_in_range(int'(prefix_sr), NUM_SR) ? prefix_sr : microcode_sr_rd_sel;

    // Next-state logic; the boundary strobe is folded in as "start from IDLE".
    always_comb begin
        base_state_s = state_r;
        state_next_s = state_r;
        if (next_instruction) begin
            base_state_s = IDLE;
        end else begin
            base_state_s = state_r;
        end
        case (base_state_s)
            IDLE: begin
                if (opcode_start) begin
                    state_next_s = EXEC;
                end else if (prefix_valid) begin
                    state_next_s = COLLECT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COLLECT: begin
                if (opcode_start) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = COLLECT;
                end
            end
            EXEC:    state_next_s = EXEC;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Prefix flags: boundary clears, then an accepted prefix sets its flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            override_r      <= {SR_W{1'b0}};
            override_active <= 1'b0;
            rep_active      <= 1'b0;
            rep_ne          <= 1'b0;
            lock_active     <= 1'b0;
        end else begin
            if (next_instruction) begin
                override_r      <= {SR_W{1'b0}};
                override_active <= 1'b0;
                rep_active      <= 1'b0;
                rep_ne          <= 1'b0;
                lock_active     <= 1'b0;
            end
            if (accept_s) begin
                case (prefix_kind)
                    SEG: begin
                        override_r      <= seg_sr_s;
                        override_active <= 1'b1;
                    end
                    REP: begin
                        rep_active <= 1'b1;
                        rep_ne     <= 1'b0;
                    end
                    REPNE: begin
                        rep_active <= 1'b1;
                        rep_ne     <= 1'b1;
                    end
                    LOCK:    lock_active <= 1'b1;
                    default: lock_active <= lock_active;
                endcase
            end
        end
    end

    sat_counter #(
        .MAX (MAX_PREFIXES),
        .W   (CNT_W)
    ) u_count (
        .clk      (clk),
        .reset    (reset),
        .clear    (next_instruction),
        .inc      (accept_s),
        .count    (prefix_count),
        .overflow (prefix_overflow)
    );

    // Segment select priority: microcode force, live SEG prefix bypass,
    // latched override, BP default, microcode default.
    always_comb begin
        sr_rd_sel = microcode_sr_rd_sel;
        if (force_segment) begin
            sr_rd_sel = microcode_sr_rd_sel;
        end else if (seg_now_s) begin
            sr_rd_sel = seg_sr_s;
        end else if (override_active) begin
            sr_rd_sel = override_r;
        end else if (bp_is_base) begin
            sr_rd_sel = SR_W'(BP_SR);
        end else begin
            sr_rd_sel = microcode_sr_rd_sel;
        end
    end

endmodule

// File: tb/tb_prefix_tracker.sv
// tb_prefix_tracker: directed bench for prefix_tracker. Main instance uses
// four segment registers; a second six-register instance covers FS/GS and
// clamping of out-of-range segment indices.
module tb_prefix_tracker;
    import prefix_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         next_instruction;
    logic         prefix_valid;
    prefix_kind_t prefix_kind;
    logic [1:0]   prefix_sr;
    logic         opcode_start;
    logic         force_segment;
    logic         bp_is_base;
    logic [1:0]   microcode_sr_rd_sel;
    logic [1:0]   sr_rd_sel;
    logic         override_active;
    logic         rep_active;
    logic         rep_ne;
    logic         lock_active;
    logic [3:0]   prefix_count;
    logic         prefix_overflow;

    logic [2:0]   prefix_sr6;
    logic [2:0]   microcode6;
    logic [2:0]   sr_rd_sel6;
    logic         override_active6;
    logic         rep_active6;
    logic         rep_ne6;
    logic         lock_active6;
    logic [3:0]   prefix_count6;
    logic         prefix_overflow6;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    prefix_tracker dut (
        .clk                 (clk),
        .reset               (reset),
        .next_instruction    (next_instruction),
        .prefix_valid        (prefix_valid),
        .prefix_kind         (prefix_kind),
        .prefix_sr           (prefix_sr),
        .opcode_start        (opcode_start),
        .force_segment       (force_segment),
        .bp_is_base          (bp_is_base),
        .microcode_sr_rd_sel (microcode_sr_rd_sel),
        .sr_rd_sel           (sr_rd_sel),
        .override_active     (override_active),
        .rep_active          (rep_active),
        .rep_ne              (rep_ne),
        .lock_active         (lock_active),
        .prefix_count        (prefix_count),
        .prefix_overflow     (prefix_overflow)
    );

    prefix_tracker #(.NUM_SR(6)) dut6 (
        .clk                 (clk),
        .reset               (reset),
        .next_instruction    (next_instruction),
        .prefix_valid        (prefix_valid),
        .prefix_kind         (prefix_kind),
        .prefix_sr           (prefix_sr6),
        .opcode_start        (opcode_start),
        .force_segment       (force_segment),
        .bp_is_base          (bp_is_base),
        .microcode_sr_rd_sel (microcode6),
        .sr_rd_sel           (sr_rd_sel6),
        .override_active     (override_active6),
        .rep_active          (rep_active6),
        .rep_ne              (rep_ne6),
        .lock_active         (lock_active6),
        .prefix_count        (prefix_count6),
        .prefix_overflow     (prefix_overflow6)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        reset = 1'b1; next_instruction = 1'b0; prefix_valid = 1'b0; prefix_kind = SEG;
        prefix_sr = 2'd0; opcode_start = 1'b0; force_segment = 1'b0; bp_is_base = 1'b0;
        microcode_sr_rd_sel = 2'd0; prefix_sr6 = 3'd0; microcode6 = 3'd0;
        step();
        reset = 1'b0;
        #1;
        chk("rst_sel", sr_rd_sel, 0);
        chk("rst_ovr", override_active, 0);
        chk("rst_rep", rep_active, 0);
        chk("rst_lock", lock_active, 0);
        chk("rst_cnt", prefix_count, 0);
        chk("rst_ovf", prefix_overflow, 0);

        // SEG(ES) + LOCK, then reset mid-collect
        prefix_valid = 1'b1; prefix_kind = SEG; prefix_sr = 2'd0; step();
        prefix_kind = LOCK; step();
        prefix_valid = 1'b0;
        chk("col_lock", lock_active, 1);
        chk("col_ovr", override_active, 1);
        chk("col_cnt", prefix_count, 2);
        reset = 1'b1; step();
        reset = 1'b0; microcode_sr_rd_sel = 2'd3; #1;
        chk("rst2_sel", sr_rd_sel, 3);
        chk("rst2_ovr", override_active, 0);
        chk("rst2_lock", lock_active, 0);
        chk("rst2_cnt", prefix_count, 0);
        chk("rst2_rep", rep_active, 0);

        // SEG(CS) bypass, SEG(ES) wins, opcode; BP default overridden
        bp_is_base = 1'b1;
        prefix_valid = 1'b1; prefix_kind = SEG; prefix_sr = 2'd1; #1;
        chk("bypass", sr_rd_sel, 1);
        step();
        prefix_sr = 2'd0; step();
        prefix_valid = 1'b0; opcode_start = 1'b1; step();
        opcode_start = 1'b0; #1;
        chk("seg_es", sr_rd_sel, 0);
        chk("seg_cnt", prefix_count, 2);
        force_segment = 1'b1; #1;
        chk("force", sr_rd_sel, 3);
        force_segment = 1'b0;

        // No prefix: BP default then microcode default
        next_instruction = 1'b1; step();
        next_instruction = 1'b0; #1;
        chk("bp_sel", sr_rd_sel, 2);
        chk("ni_ovr", override_active, 0);
        bp_is_base = 1'b0; #1;
        chk("mc_sel", sr_rd_sel, 3);

        // REP then REPNE, opcode, five EXEC cycles
        prefix_valid = 1'b1; prefix_kind = REP; step();
        chk("rep_ne0", rep_ne, 0);
        chk("rep_act", rep_active, 1);
        prefix_kind = REPNE; step();
        prefix_valid = 1'b0; opcode_start = 1'b1; step();
        opcode_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("exec_rep", rep_active, 1);
            chk("exec_repne", rep_ne, 1);
        end
        // prefix during EXEC is ignored
        prefix_valid = 1'b1; prefix_kind = LOCK; step();
        prefix_valid = 1'b0;
        chk("exec_lock", lock_active, 0);
        chk("exec_cnt", prefix_count, 2);

        // 16 LOCK prefixes saturate the count
        next_instruction = 1'b1; step();
        next_instruction = 1'b0;
        prefix_valid = 1'b1; prefix_kind = LOCK;
        for (int i = 0; i < 15; i++) step();
        chk("cnt15", prefix_count, 15);
        chk("ovf15", prefix_overflow, 0);
        step();
        prefix_valid = 1'b0;
        chk("cnt16", prefix_count, 15);
        chk("ovf16", prefix_overflow, 1);
        next_instruction = 1'b1; step();
        next_instruction = 1'b0;
        chk("ni_cnt", prefix_count, 0);
        chk("ni_ovf", prefix_overflow, 0);

        // REP, then boundary + SEG(DS) in the same cycle
        prefix_valid = 1'b1; prefix_kind = REP; step();
        chk("pre_rep", rep_active, 1);
        next_instruction = 1'b1; prefix_kind = SEG; prefix_sr = 2'd3; step();
        next_instruction = 1'b0; prefix_valid = 1'b0;
        microcode_sr_rd_sel = 2'd0; bp_is_base = 1'b1; #1;
        chk("nip_cnt", prefix_count, 1);
        chk("nip_ovr", override_active, 1);
        chk("nip_sel", sr_rd_sel, 3);
        chk("nip_rep", rep_active, 0);

        // Prefix with opcode in the same cycle, then prefix in EXEC ignored
        bp_is_base = 1'b0;
        next_instruction = 1'b1; step();
        next_instruction = 1'b0;
        prefix_valid = 1'b1; prefix_kind = LOCK; opcode_start = 1'b1; step();
        opcode_start = 1'b0; prefix_kind = SEG; prefix_sr = 2'd2; step();
        prefix_valid = 1'b0;
        chk("po_lock", lock_active, 1);
        chk("po_cnt", prefix_count, 1);
        chk("po_ovr", override_active, 0);

        // Six-register instance: out-of-range index clamps, GS selectable
        next_instruction = 1'b1; step();
        next_instruction = 1'b0;
        microcode6 = 3'd4;
        prefix_valid = 1'b1; prefix_kind = SEG; prefix_sr6 = 3'd7; #1;
        chk("clamp_byp", sr_rd_sel6, 4);
        step();
        prefix_valid = 1'b0; #1;
        chk("clamp_sel", sr_rd_sel6, 4);
        prefix_valid = 1'b1; prefix_sr6 = 3'd5; #1;
        chk("gs_byp", sr_rd_sel6, 5);
        step();
        prefix_valid = 1'b0; #1;
        chk("gs_sel", sr_rd_sel6, 5);
        chk("gs_ovr", override_active6, 1);
        chk("gs_cnt", prefix_count6, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
